round_sequencer: RTL and testbench

//  Round-level controller for the memory game datapath.
//  - Draws one symbol per round from the LFSR and appends it to an internal pattern buffer.
//  - Plays the whole pattern back on the one-hot LEDs, then checks the player's button presses
//    one at a time (forward order, or reverse order in reverse mode).
//  - Tracks score and reports game over / win to the top level.

---
 rtl/round_sequencer.sv | 168 ++++++++++++++++
 tb/tb_round_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// Round-level controller for the memory game: grows a random symbol pattern one round at a
// time, plays it back on one-hot LEDs and checks the player's presses against it.
module round_sequencer #(
    parameter int MAX_LEN   = 32,
    parameter int ON_TICKS  = 4,
    parameter int OFF_TICKS = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tick_i,
    input  logic                         start_i,
    input  logic [1:0]                   mode_i,
    input  logic [2:0]                   rnd_sym_i,
    output logic                         rnd_en_o,
    input  logic                         btn_valid_i,
    input  logic [2:0]                   btn_sym_i,
    output logic [7:0]                   led_o,
    output logic                         input_en_o,
    output logic [$clog2(MAX_LEN+1)-1:0] score_o,
    output logic                         busy_o,
    output logic                         game_over_o,
    output logic                         win_o
);

    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int OW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_APPEND, S_SHOW_ON, S_SHOW_OFF, S_INPUT, S_OVER, S_WIN
    } state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [LW-1:0] score_q, score_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [OW-1:0] timeout_q, timeout_d;
    logic [1:0]    mode_q, mode_d;
    logic [2:0]    pat_q [MAX_LEN];
    logic          pat_we;
    logic [2:0]    cur_sym;
    logic          rev_mode;
    logic          timed_mode;
    logic          last_press;

    assign cur_sym    = pat_q[idx_q[AW-1:0]];
    assign rev_mode   = (mode_q == 2'b10);
    assign timed_mode = (mode_q == 2'b01);
    assign last_press = rev_mode ? (idx_q == '0) : (idx_q == len_q - LW'(1));

    // Pattern storage needs no reset: only entries below len are ever read.
    always_ff @(posedge clk) begin
        if (pat_we) begin
            pat_q[len_q[AW-1:0]] <= rnd_sym_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            score_q   <= '0;
            timer_q   <= '0;
            timeout_q <= '0;
            mode_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            score_q   <= score_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
            mode_q    <= mode_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        score_d   = score_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        mode_d    = mode_q;
        pat_we    = 1'b0;
        unique case (state_q)
            S_IDLE, S_OVER, S_WIN: begin
                if (start_i) begin
                    state_d = S_APPEND;
                    len_d   = '0;
                    score_d = '0;
                    mode_d  = mode_i;
                end
            end
            S_APPEND: begin
                if (len_q != LW'(MAX_LEN)) begin
                    pat_we = 1'b1;
                    len_d  = len_q + LW'(1);
                end
                idx_d   = '0;
                timer_d = TW'(ON_TICKS - 1);
                state_d = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (tick_i) begin
                    if (timer_q == '0) begin
                        state_d = S_SHOW_OFF;
                        timer_d = TW'(OFF_TICKS - 1);
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            S_SHOW_OFF: begin
                if (tick_i) begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - TW'(1);
                    end else if (idx_q + LW'(1) == len_q) begin
                        state_d   = S_INPUT;
                        idx_d     = rev_mode ? (len_q - LW'(1)) : '0;
                        timeout_d = OW'(TIMEOUT - 1);
                    end else begin
                        state_d = S_SHOW_ON;
                        idx_d   = idx_q + LW'(1);
                        timer_d = TW'(ON_TICKS - 1);
                    end
                end
            end
            S_INPUT: begin
                // A press always takes priority over a timeout expiring in the same cycle.
                if (btn_valid_i) begin
                    if (btn_sym_i != cur_sym) begin
                        state_d = S_OVER;
                    end else if (last_press) begin
                        if (score_q != LW'(MAX_LEN)) begin
                            score_d = score_q + LW'(1);
                        end
                        state_d = (len_q == LW'(MAX_LEN)) ? S_WIN : S_APPEND;
                    end else begin
                        idx_d     = rev_mode ? (idx_q - LW'(1)) : (idx_q + LW'(1));
                        timeout_d = OW'(TIMEOUT - 1);
                    end
                end else if (timed_mode && tick_i) begin
                    if (timeout_q == '0) begin
                        state_d = S_OVER;
                    end else begin
                        timeout_d = timeout_q - OW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign led_o       = (state_q == S_SHOW_ON) ? (8'b1 << cur_sym) : 8'h00;
    assign rnd_en_o    = (state_q == S_APPEND);
    assign input_en_o  = (state_q == S_INPUT);
    assign busy_o      = (state_q != S_IDLE) && (state_q != S_OVER) && (state_q != S_WIN);
    assign game_over_o = (state_q == S_OVER);
    assign win_o       = (state_q == S_WIN);
    assign score_o     = score_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: a cycle-by-cycle vector table for a two-round classic
// game, plus short sequences for reverse, timed, win, ignored-input and reset corner cases.
module tb_round_sequencer;

    localparam int MAX_LEN   = 4;
    localparam int ON_TICKS  = 4;
    localparam int OFF_TICKS = 2;
    localparam int TIMEOUT   = 16;
    localparam int SW        = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick_i = 1'b0;
    logic          start_i = 1'b0;
    logic [1:0]    mode_i = 2'b00;
    logic [2:0]    rnd_sym_i = 3'd0;
    logic          btn_valid_i = 1'b0;
    logic [2:0]    btn_sym_i = 3'd0;
    logic          rnd_en_o;
    logic [7:0]    led_o;
    logic          input_en_o;
    logic [SW-1:0] score_o;
    logic          busy_o;
    logic          game_over_o;
    logic          win_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          tick;
        logic          start;
        logic [1:0]    mode;
        logic [2:0]    rsym;
        logic          bv;
        logic [2:0]    bsym;
        logic [7:0]    led;
        logic          inEn;
        logic          busy;
        logic          over;
        logic          win;
        logic [SW-1:0] score;
        logic          rnd;
    } vec_t;

    vec_t vecs[$];

    round_sequencer #(
        .MAX_LEN  (MAX_LEN),
        .ON_TICKS (ON_TICKS),
        .OFF_TICKS(OFF_TICKS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_i     (tick_i),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .rnd_sym_i  (rnd_sym_i),
        .rnd_en_o   (rnd_en_o),
        .btn_valid_i(btn_valid_i),
        .btn_sym_i  (btn_sym_i),
        .led_o      (led_o),
        .input_en_o (input_en_o),
        .score_o    (score_o),
        .busy_o     (busy_o),
        .game_over_o(game_over_o),
        .win_o      (win_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic t, input logic s, input logic [1:0] m,
                                input logic [2:0] rs, input logic b, input logic [2:0] bs,
                                input logic [7:0] l, input logic ie, input logic bu,
                                input logic ov, input logic wn, input logic [SW-1:0] sc,
                                input logic re);
        vec_t v;
        v.tick = t; v.start = s; v.mode = m; v.rsym = rs; v.bv = b; v.bsym = bs;
        v.led = l; v.inEn = ie; v.busy = bu; v.over = ov; v.win = wn; v.score = sc; v.rnd = re;
        return v;
    endfunction

    function automatic logic [31:0] packOut();
        return 32'({led_o, input_en_o, busy_o, game_over_o, win_o, score_o, rnd_en_o});
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1ns after the edge and drop the pulses.
    task automatic applyStimulus(input logic t, input logic s, input logic [1:0] m,
                                 input logic [2:0] rs, input logic b, input logic [2:0] bs);
        tick_i = t; start_i = s; mode_i = m; rnd_sym_i = rs; btn_valid_i = b; btn_sym_i = bs;
        @(posedge clk);
        #1;
        tick_i = 1'b0; start_i = 1'b0; btn_valid_i = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("reset_state", packOut(), 32'h0);
    endtask

    task automatic startGame(input logic [1:0] m);
        applyStimulus(1'b0, 1'b1, m, 3'd0, 1'b0, 3'd0);
        checkOutput("start_rnd_en", 32'(rnd_en_o), 32'h1);
    endtask

    task automatic waitInput();
        int n = 0;
        while (!input_en_o && n < 64) begin
            applyStimulus(1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 3'd0);
            n++;
        end
        checkOutput("reach_input", 32'(input_en_o), 32'h1);
    endtask

    task automatic appendAndShow(input logic [2:0] sym);
        applyStimulus(1'b1, 1'b0, 2'b00, sym, 1'b0, 3'd0);
        waitInput();
    endtask

    task automatic press(input logic [2:0] sym);
        applyStimulus(1'b0, 1'b0, 2'b00, 3'd0, 1'b1, sym);
    endtask

    task automatic tickN(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 3'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [2:0] winSyms [4];

        // Classic game, LFSR 3 then 5; tick held high through playback.
        vecs.push_back(mk(0,1,0,0,0,0, 8'h00,0,1,0,0,0,1));
        vecs.push_back(mk(1,0,0,3,0,0, 8'h08,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 8'h08,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 8'h08,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 8'h08,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 8'h00,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 8'h00,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 8'h00,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,3, 8'h00,0,1,0,0,1,1));
        vecs.push_back(mk(1,0,0,5,0,0, 8'h08,0,1,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,0, 8'h08,0,1,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,0, 8'h08,0,1,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,0, 8'h08,0,1,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,0, 8'h00,0,1,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,0, 8'h00,0,1,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,0, 8'h20,0,1,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,0, 8'h20,0,1,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,0, 8'h20,0,1,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,0, 8'h20,0,1,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,0, 8'h00,0,1,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,0, 8'h00,0,1,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,0, 8'h00,1,1,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,1,3, 8'h00,1,1,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,1,5, 8'h00,0,1,0,0,2,1));
        vecs.push_back(mk(0,0,0,1,0,0, 8'h08,0,1,0,0,2,0));

        doReset();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].tick, vecs[i].start, vecs[i].mode, vecs[i].rsym,
                          vecs[i].bv, vecs[i].bsym);
            checkOutput($sformatf("vec%0d", i), packOut(),
                        32'({vecs[i].led, vecs[i].inEn, vecs[i].busy, vecs[i].over,
                             vecs[i].win, vecs[i].score, vecs[i].rnd}));
        end

        // Asynchronous reset while playback is lit.
        #2 rst_n = 1'b0;
        #1 checkOutput("rst_mid_show", packOut(), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Wrong second press ends the game; start wins over a press in OVER.
        doReset();
        startGame(2'b00);
        appendAndShow(3'd3);
        press(3'd3);
        checkOutput("t2_score1", 32'(score_o), 32'd1);
        appendAndShow(3'd5);
        press(3'd3);
        checkOutput("t2_mid_input", 32'(input_en_o), 32'h1);
        press(3'd6);
        checkOutput("t2_over", 32'(game_over_o), 32'h1);
        checkOutput("t2_over_score", 32'(score_o), 32'd1);
        checkOutput("t2_over_inen", 32'(input_en_o), 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b00, 3'd0, 1'b1, 3'd3);
        checkOutput("t2_restart_over", 32'(game_over_o), 32'h0);
        checkOutput("t2_restart_rnd", 32'(rnd_en_o), 32'h1);
        checkOutput("t2_restart_score", 32'(score_o), 32'd0);

        // Reverse mode: pattern 1,4,7 answered backwards.
        doReset();
        startGame(2'b10);
        appendAndShow(3'd1);
        press(3'd1);
        checkOutput("t3_r1_score", 32'(score_o), 32'd1);
        appendAndShow(3'd4);
        press(3'd4);
        checkOutput("t3_r2_mid", 32'({input_en_o, score_o}), 32'({1'b1, SW'(1)}));
        press(3'd1);
        checkOutput("t3_r2_score", 32'(score_o), 32'd2);
        appendAndShow(3'd7);
        press(3'd7);
        press(3'd4);
        press(3'd1);
        checkOutput("t3_r3_score", 32'(score_o), 32'd3);
        checkOutput("t3_r3_append", 32'(rnd_en_o), 32'h1);

        // Reverse mode answered forwards fails on the first press.
        doReset();
        startGame(2'b10);
        appendAndShow(3'd1);
        press(3'd1);
        appendAndShow(3'd4);
        press(3'd4);
        press(3'd1);
        appendAndShow(3'd7);
        press(3'd1);
        checkOutput("t3_fwd_over", 32'(game_over_o), 32'h1);
        checkOutput("t3_fwd_score", 32'(score_o), 32'd2);

        // Timed mode: 15 ticks survive, the 16th expires.
        doReset();
        startGame(2'b01);
        appendAndShow(3'd3);
        tickN(15);
        checkOutput("t4_15_ticks", 32'({input_en_o, game_over_o}), 32'b10);
        tickN(1);
        checkOutput("t4_timeout", 32'({input_en_o, game_over_o}), 32'b01);

        // Timed mode: a correct press on the expiring tick is taken.
        doReset();
        startGame(2'b01);
        appendAndShow(3'd3);
        tickN(15);
        applyStimulus(1'b1, 1'b0, 2'b00, 3'd0, 1'b1, 3'd3);
        checkOutput("t4_press_wins", 32'({game_over_o, rnd_en_o}), 32'b01);
        checkOutput("t4_press_score", 32'(score_o), 32'd1);

        // Classic mode never times out.
        doReset();
        startGame(2'b00);
        appendAndShow(3'd2);
        tickN(20);
        checkOutput("t4_classic_no_to", 32'({input_en_o, game_over_o}), 32'b10);

        // Four correct rounds reach MAX_LEN and win; a press during playback is ignored.
        winSyms[0] = 3'd0; winSyms[1] = 3'd1; winSyms[2] = 3'd2; winSyms[3] = 3'd7;
        doReset();
        startGame(2'b00);
        for (int r = 0; r < 4; r++) begin
            if (r == 3) begin
                applyStimulus(1'b0, 1'b0, 2'b00, winSyms[r], 1'b0, 3'd0);
                checkOutput("t5_show_led", 32'(led_o), 32'h01);
                applyStimulus(1'b0, 1'b0, 2'b00, 3'd0, 1'b1, 3'd0);
                checkOutput("t5_btn_ignored", 32'({led_o, input_en_o, score_o}),
                            32'({8'h01, 1'b0, SW'(3)}));
                waitInput();
            end else begin
                appendAndShow(winSyms[r]);
            end
            for (int k = 0; k <= r; k++) press(winSyms[k]);
        end
        checkOutput("t5_win", 32'({win_o, busy_o, game_over_o}), 32'b100);
        checkOutput("t5_win_score", 32'(score_o), 32'd4);
        applyStimulus(1'b0, 1'b1, 2'b00, 3'd0, 1'b1, 3'd0);
        checkOutput("t5_restart", 32'({win_o, rnd_en_o, score_o}), 32'({1'b0, 1'b1, SW'(0)}));

        // Start while busy has no effect on playback.
        doReset();
        startGame(2'b00);
        applyStimulus(1'b0, 1'b0, 2'b00, 3'd6, 1'b0, 3'd0);
        checkOutput("t6_show_led", 32'(led_o), 32'h40);
        applyStimulus(1'b0, 1'b1, 2'b00, 3'd0, 1'b0, 3'd0);
        checkOutput("t6_start_busy", 32'({led_o, rnd_en_o, busy_o}), 32'({8'h40, 1'b0, 1'b1}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
